// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the program-ROM download/CPU arbiter.
// Imported by dl_fifo and rom_dl_arbiter.
package rom_dl_pkg;

    localparam int AW_DEF         = 16;
    localparam int DW_DEF         = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ROM_SIZE_DEF   = 49152;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR
    } arb_state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Download write buffer: synchronous FIFO of {addr, data} entries.
// Reset flushes the pointers; storage is left as-is.
module dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  dl_entry_t              i_din,
    input  logic                   i_pop,
    output dl_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    dl_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rp];

    // A push into a full FIFO is still taken when a pop frees the slot.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares one single-port program-ROM BRAM between the HPS download
// stream (buffered) and the CPU read port; flags when the image is in.
module rom_dl_arbiter
    import rom_dl_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ROM_SIZE   = ROM_SIZE_DEF
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          dn_download,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [DW-1:0] dn_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          rom_ready,
    output logic          dn_ovf
);

    arb_state_t r_state;
    arb_state_t w_next;

    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_we;
    logic [DW-1:0] r_rdata;
    logic          r_ack;
    logic          r_dl_d;
    logic          r_rom_ready;
    logic          r_ovf;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_dl_rise;
    logic          w_drop;
    dl_entry_t     w_push_ent;
    dl_entry_t     w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_push = dn_wr && (32'(dn_addr) < 32'(ROM_SIZE));
    assign w_push_ent.addr = dn_addr;
    assign w_push_ent.data = dn_data;

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (RESET_N),
        .i_push  (w_push),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A full FIFO outranks the CPU so download writes cannot starve.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_full) begin
                    w_next = S_WR;
                    w_pop  = 1'b1;
                end else if (cpu_req) begin
                    w_next = S_RD;
                end else if (!w_empty) begin
                    w_next = S_WR;
                    w_pop  = 1'b1;
                end
            end
            S_RD:    w_next = S_RDW;
            S_RDW:   w_next = S_IDLE;
            S_WR:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // BRAM port registers load on entry to RD/WR so they hold through it.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= w_pop;
            r_ack    <= (r_state == S_RDW);
            if (r_state == S_RDW) r_rdata <= mem_dout;
            if (w_pop) begin
                r_mem_addr <= w_head.addr;
                r_mem_din  <= w_head.data;
            end else if (r_state == S_IDLE && w_next == S_RD) begin
                r_mem_addr <= cpu_addr;
            end
        end
    end

    assign w_dl_rise = dn_download && !r_dl_d;
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dl_d      <= 1'b0;
            r_rom_ready <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_dl_d <= dn_download;
            if (w_dl_rise) begin
                r_rom_ready <= 1'b0;
            end else if (!dn_download && w_count == '0 && r_state != S_WR) begin
                r_rom_ready <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_dl_rise) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_we    = r_mem_we;
    assign cpu_rdata = r_rdata;
    assign cpu_ack   = r_ack;
    assign rom_ready = r_rom_ready;
    assign dn_ovf    = r_ovf;

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Bench for rom_dl_arbiter: BRAM model, transaction-level reference
// (write order, occupancy, shadow ROM) and directed plus random traffic.
module tb_rom_dl_arbiter;

    localparam int DEPTH    = 4;
    localparam int ROM_SIZE = 49152;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic        rom_ready;
    logic        dn_ovf;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] bram    [65536];
    logic [7:0] ref_mem [65536];

    rom_dl_arbiter dut (
        .clk_sys     (clk_sys),
        .RESET_N     (RESET_N),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .rom_ready   (rom_ready),
        .dn_ovf      (dn_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_q[$];
    int   acc = 0;
    int   wtot = 0;
    int   we_seen = 0;
    int   drops = 0;
    logic exp_rdy = 1'b0;
    logic exp_ovf = 1'b0;
    logic [7:0] exp_rdata = '0;

    logic p_rst = 1'b1;
    logic p_push = 1'b0;
    logic p_dl = 1'b0;
    logic p_dl_rise = 1'b0;
    logic p_empty = 1'b1;
    logic p_we = 1'b0;
    int   p_occ = 0;
    logic [15:0] p_push_a = '0;
    logic [7:0]  p_push_d = '0;

    always @(negedge clk_sys) begin
        logic we_c;
        logic drop_c;
        int   occ;
        wr_t  e;
        if (!RESET_N) begin
            chk("reset_outputs",
                {28'd0, cpu_ack, mem_we, rom_ready, dn_ovf, cpu_rdata, mem_din, mem_addr}, 64'd0);
            exp_q.delete();
            acc = 0; wtot = 0;
            exp_rdy = 1'b0; exp_ovf = 1'b0; exp_rdata = '0;
            p_rst = 1'b1; p_push = 1'b0; p_dl = 1'b0; p_dl_rise = 1'b0;
            p_empty = 1'b1; p_we = 1'b0; p_occ = 0;
        end else begin
            we_c   = mem_we;
            drop_c = 1'b0;
            // last cycle's push is kept if a slot was free or a pop freed one
            if (p_push) begin
                if (p_occ < DEPTH || we_c) begin
                    exp_q.push_back('{a: p_push_a, d: p_push_d});
                    acc++;
                end else begin
                    drop_c = 1'b1;
                    drops++;
                end
            end
            if (we_c) begin
                we_seen++;
                chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(mem_addr), 64'(e.a));
                    chk("write_data", 64'(mem_din), 64'(e.d));
                    ref_mem[e.a] = e.d;
                end
                wtot++;
            end
            occ = acc - wtot;
            if (p_rst || p_dl_rise) exp_rdy = 1'b0;
            else if (!p_dl && p_empty && !p_we) exp_rdy = 1'b1;
            if (p_rst) exp_ovf = 1'b0;
            else if (drop_c) exp_ovf = 1'b1;
            else if (p_dl_rise) exp_ovf = 1'b0;
            chk("rom_ready", 64'(rom_ready), 64'(exp_rdy));
            chk("dn_ovf", 64'(dn_ovf), 64'(exp_ovf));
            if (cpu_ack) begin
                chk("ack_with_req", 64'(cpu_req), 64'd1);
                exp_rdata = ref_mem[cpu_addr];
            end
            chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
            p_dl_rise = dn_download && !p_dl;
            p_dl      = dn_download;
            p_empty   = (occ == 0);
            p_we      = we_c;
            p_occ     = occ;
            p_push    = dn_wr && (32'(dn_addr) < 32'(ROM_SIZE));
            p_push_a  = dn_addr;
            p_push_d  = dn_data;
            p_rst     = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
        dn_wr = 1'b1; dn_addr = a; dn_data = d;
        tick(1);
        dn_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output int lat, output logic [7:0] d);
        logic got;
        got = 1'b0; lat = -1; d = '0;
        cpu_req = 1'b1; cpu_addr = a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin
                got = 1'b1; lat = k; d = cpu_rdata;
                break;
            end
        end
        #1 cpu_req = 1'b0;
        chk("read_done", 64'(got), 64'd1);
        tick(1);
    endtask

    task automatic wait_ack_drop();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
        #1 cpu_req = 1'b0;
        chk("ack_for_drop", 64'(got), 64'd1);
        tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] d;
        int         we0;
        int         d0;
        int         acks;

        for (int i = 0; i < 65536; i++) begin
            bram[i]    = 8'(i) ^ 8'(i >> 8);
            ref_mem[i] = 8'(i) ^ 8'(i >> 8);
        end
        bram[16'h1234]    = 8'hA5;
        ref_mem[16'h1234] = 8'hA5;

        // reset then read
        tick(3);
        chk("rst_ack", 64'(cpu_ack), 64'd0);
        chk("rst_ready", 64'(rom_ready), 64'd0);
        RESET_N = 1'b1;
        tick(2);
        cpu_read(16'h1234, lat, d);
        chk("read_latency", 64'(lat), 64'd3);
        chk("read_data", 64'(d), 64'hA5);
        chk("read_no_write", 64'(we_seen), 64'd0);

        // single download write
        dn_download = 1'b1;
        tick(2);
        dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h3C;
        @(negedge clk_sys);
        chk("wr_lat_c0", 64'(mem_we), 64'd0);
        tick(1);
        dn_wr = 1'b0;
        @(negedge clk_sys);
        chk("wr_lat_c1", 64'(mem_we), 64'd0);
        @(negedge clk_sys);
        chk("wr_lat_c2_we", 64'(mem_we), 64'd1);
        chk("wr_lat_c2_addr", 64'(mem_addr), 64'h0010);
        chk("wr_lat_c2_din", 64'(mem_din), 64'h3C);
        tick(1);
        dn_download = 1'b0;
        @(negedge clk_sys);
        chk("ready_before", 64'(rom_ready), 64'd0);
        @(negedge clk_sys);
        chk("ready_after_fall", 64'(rom_ready), 64'd1);
        tick(1);

        // out-of-range write
        dn_download = 1'b1;
        tick(2);
        we0 = we_seen;
        dl_write(16'hC000, 8'h77);
        tick(5);
        chk("oor_no_write", 64'(we_seen - we0), 64'd0);
        chk("oor_no_ovf", 64'(dn_ovf), 64'd0);

        // contention: streaming reads, six back-to-back pushes
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        tick(2);
        we0 = we_seen; d0 = drops;
        for (int i = 0; i < 6; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0200 + 16'(i); dn_data = 8'h50 + 8'(i);
            tick(1);
        end
        dn_wr = 1'b0;
        tick(4);
        chk("cont_ovf_set", 64'(dn_ovf), 64'd1);
        chk("cont_forced_wr", 64'(we_seen > we0), 64'd1);
        wait_ack_drop();
        tick(20);
        chk("cont_drop_seen", 64'(drops > d0), 64'd1);
        chk("cont_all_kept_written", 64'(we_seen - we0), 64'(6 - (drops - d0)));

        // new download clears rom_ready and dn_ovf
        dn_download = 1'b0;
        tick(4);
        chk("pre_rise_ready", 64'(rom_ready), 64'd1);
        chk("pre_rise_ovf", 64'(dn_ovf), 64'd1);
        dn_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rise_clr_ready", 64'(rom_ready), 64'd0);
        chk("rise_clr_ovf", 64'(dn_ovf), 64'd0);
        tick(1);

        // randomized traffic with download spacing of 4..7 cycles
        fork
            begin
                logic [15:0] a;
                for (int i = 0; i < 60; i++) begin
                    a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                    dl_write(a, 8'($urandom));
                    tick($urandom_range(3, 6));
                end
            end
            begin
                int         rl;
                logic [7:0] rd;
                for (int i = 0; i < 50; i++) begin
                    cpu_read(16'($urandom_range(0, 255)), rl, rd);
                    tick($urandom_range(0, 3));
                end
            end
        join
        dn_download = 1'b0;
        tick(12);
        chk("rand_no_ovf", 64'(dn_ovf), 64'd0);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_ready", 64'(rom_ready), 64'd1);

        // reset during RDW with a write still buffered
        cpu_req = 1'b1; cpu_addr = 16'h1234;
        dn_wr = 1'b1; dn_addr = 16'h0300; dn_data = 8'hEE;
        tick(1);
        dn_wr = 1'b0;
        tick(1);
        RESET_N = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk_sys);
        chk("mid_rst_ack", 64'(cpu_ack), 64'd0);
        chk("mid_rst_ready", 64'(rom_ready), 64'd0);
        tick(2);
        RESET_N = 1'b1;
        we0 = we_seen;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            if (cpu_ack) acks++;
        end
        chk("mid_rst_no_ack", 64'(acks), 64'd0);
        chk("mid_rst_flushed", 64'(we_seen - we0), 64'd0);
        chk("mid_rst_ready_after", 64'(rom_ready), 64'd1);
        tick(1);
        cpu_read(16'h1234, lat, d);
        chk("post_rst_read", 64'(d), 64'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_dl_arbiter.md
# rom_dl_arbiter

Single-clock arbiter sharing one single-port program-ROM BRAM between the HPS ROM-download stream (`hps_io` ioctl interface) and the CPU read port of `williams_cpu`. Download writes are buffered in a small FIFO so none is lost while a CPU read is in flight. A `rom_ready` flag tells the top level when the image is fully committed. The block sits between `hps_io`/`williams_cpu` and the ROM RAM instance.

## Interface
Parameters:
- `AW`, 16, address width of ROM and download address.
- `DW`, 8, data width.
- `FIFO_DEPTH`, 4, download write buffer entries (power of two, ≥2).
- `ROM_SIZE`, 49152, bytes accepted; downloads at `dn_addr >= ROM_SIZE` are discarded.

Ports:
- `clk_sys`  in  1  single clock for the whole block.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `dn_download`  in  1  download in progress (ioctl_download).
- `dn_wr`  in  1  one-cycle write strobe.
- `dn_addr`  in  AW  download byte address.
- `dn_data`  in  DW  download byte.
- `cpu_req`  in  1  read request, level, held until `cpu_ack`.
- `cpu_addr`  in  AW  read address, stable while `cpu_req`.
- `cpu_rdata`  out  DW  read data, valid in the `cpu_ack` cycle and held until the next ack.
- `cpu_ack`  out  1  one-cycle read completion pulse.
- `mem_addr`  out  AW  BRAM address (registered).
- `mem_din`  out  DW  BRAM write data (registered).
- `mem_we`  out  1  BRAM write enable (registered).
- `mem_dout`  in  DW  BRAM read data, 1-cycle latency after `mem_addr`.
- `rom_ready`  out  1  image committed.
- `dn_ovf`  out  1  sticky: a download byte was dropped on a full FIFO.

## Operation
- **Clock and reset:** one clock, `clk_sys`. Reset is asynchronous and active-low on `RESET_N`.
- **FIFO:**
  - `dn_wr` with `dn_addr < ROM_SIZE` pushes {addr, data}.
  - A push with the FIFO full and no pop in the same cycle drops the byte and sets `dn_ovf`.
  - A push and a pop in the same cycle while full is legal; the count is unchanged.
  - Out-of-range writes are ignored silently.
- **FSM states:** IDLE, RD, RDW, WR.
- **IDLE priority:**
  1. FIFO full → WR.
  2. `cpu_req` → RD.
  3. FIFO non-empty → WR.
  4. Otherwise stay in IDLE.
- **RD:** drive `mem_addr=cpu_addr`, `mem_we=0` → RDW.
- **RDW:** `mem_dout` valid. Capture it into `cpu_rdata`, pulse `cpu_ack` → IDLE.
- **WR:** pop the FIFO head, drive `mem_addr`/`mem_din`, `mem_we=1` for exactly one cycle → IDLE.
- **CPU handshake:** the CPU deasserts `cpu_req` the cycle after `cpu_ack`. A `cpu_req` still high in IDLE after an ack is treated as a new request.
- **`rom_ready`:**
  - Cleared on the `dn_download` rising edge.
  - Set when `dn_download`=0, the FIFO is empty and the FSM is not in WR.
  - `dn_ovf` is cleared on the `dn_download` rising edge.
- **Reset mid-operation:** the FIFO is flushed, the FSM returns to IDLE, any pending read is abandoned with no ack, and outputs return to their reset values.

## Timing
- **Reset values:**
  - `cpu_ack`=0, `cpu_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `rom_ready`=0, `dn_ovf`=0.
  - FIFO count=0, state IDLE.
- **Read latency:** `cpu_req` sampled high in IDLE at cycle n (FIFO not full) → `mem_addr` at n+1 → `cpu_ack` and `cpu_rdata` at n+3.
- **Write latency:** a push at cycle n into an empty FIFO with the FSM idle → `mem_we` high at n+2 (pop at n+1, registered BRAM write).
- **Throughput:**
  - One BRAM access per FSM pass: a read takes 3 cycles, a write 2 cycles including IDLE.
  - Worst-case write wait while reads stream is bounded: FIFO full forces WR.
- **Sustained download rate:** `hps_io` spacing of ≥4 cycles per byte never overflows with `FIFO_DEPTH`≥2.
- **`rom_ready` latency:** asserts one cycle after the last committing WR cycle, or after the `dn_download` fall, whichever is later.

## Structure
- Shared package `rom_dl_pkg`:
  - FSM state enum `arb_state_t`.
  - FIFO entry struct `dl_entry_t` {addr, data}.
  - Default parameter constants.
- One sub-module: `dl_fifo`, a synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- The arbiter FSM and `rom_ready`/`dn_ovf` logic live in the top module.

## Test plan
- **Reset then read:** release `RESET_N`, preload BRAM model addr 0x1234=0xA5, raise `cpu_req` with `cpu_addr`=0x1234 → `cpu_ack` exactly 3 cycles later, `cpu_rdata`=0xA5, `mem_we` never high.
- **Single download write:** `dn_download`=1, `dn_wr` at 0x0010 data 0x3C, no CPU → `mem_we` high 2 cycles later with addr 0x0010, din 0x3C. Drop `dn_download` → `rom_ready`=1 next cycle.
- **Out-of-range write:** `dn_wr` at 0xC000 (≥ `ROM_SIZE`) → no push, `mem_we` stays 0, `dn_ovf`=0.
- **Contention:** continuous back-to-back `cpu_req` while 4 `dn_wr` arrive 1 cycle apart → FIFO reaches full, next IDLE selects WR, all 4 bytes written in order, `dn_ovf`=0 unless a 5th push lands while full with no pop (then `dn_ovf`=1 and that byte absent).
- **Reset mid-read:** assert `RESET_N`=0 during RDW → `cpu_ack` never pulses, FIFO count=0, `rom_ready`=0, state IDLE after release.
- **New download:** `rom_ready`=1 and `dn_ovf`=1, then `dn_download` rises → both cleared the next cycle.
